// File: rtl/barrel_rotator_param.sv
// barrel_rotator_param
//   N-entry register file r and N-entry rotating shifter b, each entry W bits.
//   Both arrays are filled in order through a valid/ready port (FILL state).
//   After the last entry is written the block enters RUN.
//   In RUN, r holds its contents while b rotates up or down by a runtime amount.
//   A registered monitor reports whether r(i)==b(j) implies
//   r(i+1 mod N)==b(j+1 mod N) for every i,j.
//
// Build option
//   INV_CHECK_EN : defining it builds the invariant comparator and its assertion.
//                  Left undefined, both are removed and inv_ok is tied high.
//
// Ports
//   clock, reset            rising-edge clock, synchronous active-high reset
//   load_valid/load_ready   fill handshake; load_ready is high only in FILL
//   load_data [W]           value written to b[fill_ptr] and r[fill_ptr]
//   flush                   clears both arrays and returns to FILL; wins over load and rotate
//   rot_en, rot_dir         rotate b in RUN; dir 0 = up, 1 = down
//   rot_amt [AW]            rotation distance mod N
//   b_flat, r_flat [N*W]    array contents, entry k at [k*W +: W]
//   running                 high in RUN
//   rot_count [AW]          net rotation offset mod N since RUN entry
//   inv_ok                  registered invariant result, forced high outside RUN
module barrel_rotator_param #(
    parameter int unsigned N  = 4,
    parameter int unsigned W  = $clog2(N),
    parameter int unsigned AW = $clog2(N)
) (
    input  logic      clock,
    input  logic      reset,
    input  logic      load_valid,
    output logic      load_ready,
    input  logic [W-1:0]   load_data,
    input  logic      flush,
    input  logic      rot_en,
    input  logic      rot_dir,
    input  logic [AW-1:0]  rot_amt,
    output logic [N*W-1:0] b_flat,
    output logic [N*W-1:0] r_flat,
    output logic      running,
    output logic [AW-1:0]  rot_count,
    output logic      inv_ok
);

    // Elaboration-time parameter checks
    if ((N < 2) || ((N & (N - 1)) != 0)) begin : g_bad_n
        $error("barrel_rotator_param: N must be a power of 2 and >= 2");
    end
    if (W < $clog2(N)) begin : g_bad_w
        $error("barrel_rotator_param: W must be >= $clog2(N)");
    end
    if (AW != $clog2(N)) begin : g_bad_aw
        $error("barrel_rotator_param: AW is derived and must not be overridden");
    end

    typedef enum logic {FILL = 1'b0, RUN = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  b_q [N];
    logic [W-1:0]  r_q [N];
    logic [W-1:0]  b_d [N];
    logic [W-1:0]  r_d [N];
    logic [AW-1:0] ptr_q, ptr_d;
    logic [AW-1:0] cnt_q, cnt_d;

    // State register; load_ready/running are registered decodes of the next state
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= FILL;
            load_ready <= 1'b1;
            running    <= 1'b0;
        end else begin
            state_q    <= state_d;
            load_ready <= (state_d == FILL);
            running    <= (state_d == RUN);
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = FILL;
        end else begin
            case (state_q)
                FILL:    if (load_valid && (ptr_q == AW'(N - 1))) state_d = RUN;
                RUN:     state_d = RUN;
                default: state_d = FILL;
            endcase
        end
    end

    // Datapath next values: fill writes, rotation, flush clear
    always_comb begin
        b_d   = b_q;
        r_d   = r_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (flush) begin
            b_d   = '{default: '0};
            r_d   = '{default: '0};
            ptr_d = '0;
            cnt_d = '0;
        end else begin
            case (state_q)
                FILL: begin
                    if (load_valid) begin
                        b_d[ptr_q] = load_data;
                        r_d[ptr_q] = load_data;
                        ptr_d      = AW'(ptr_q + 1'b1);
                    end
                end
                RUN: begin
                    if (rot_en) begin
                        // AW-bit index arithmetic wraps mod N because N == 2**AW
                        for (int i = 0; i < N; i++) begin
                            b_d[i] = b_q[rot_dir ? AW'(AW'(i) - rot_amt)
                                                 : AW'(AW'(i) + rot_amt)];
                        end
                        cnt_d = rot_dir ? AW'(cnt_q - rot_amt) : AW'(cnt_q + rot_amt);
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            b_q   <= '{default: '0};
            r_q   <= '{default: '0};
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            b_q   <= b_d;
            r_q   <= r_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    // Flat output packing
    for (genvar k = 0; k < N; k++) begin : g_pack
        assign b_flat[k*W +: W] = b_q[k];
        assign r_flat[k*W +: W] = r_q[k];
    end
    assign rot_count = cnt_q;

`ifdef INV_CHECK_EN
    logic inv_c;
    logic inv_q;

    // Neighbour invariant over all N*N (i,j) pairs
    always_comb begin
        inv_c = 1'b1;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if ((r_q[i] == b_q[j]) && (r_q[AW'(i + 1)] != b_q[AW'(j + 1)])) begin
                    inv_c = 1'b0;
                end
            end
        end
    end

    // Only meaningful once both arrays are complete; a flush discards the contents
    always_ff @(posedge clock) begin
        if (reset) begin
            inv_q <= 1'b1;
        end else begin
            inv_q <= ((state_q == RUN) && !flush) ? inv_c : 1'b1;
        end
    end
    assign inv_ok = inv_q;

    // Rotation must not break a holding invariant. The first RUN cycle still shows
    // the forced FILL value, so the check starts once a real result has been seen.
    a_inv_hold: assert property (@(posedge clock) disable iff (reset)
        (running && $past(running, 2) && $past(inv_ok && running && !flush)) |-> inv_ok)
        else $error("barrel_rotator_param: invariant lost during rotation");
`else
    assign inv_ok = 1'b1;
`endif

endmodule

// File: tb/tb_barrel_rotator_param.sv
module tb_barrel_rotator_param;

    localparam int unsigned N  = 4;
    localparam int unsigned W  = 2;
    localparam int unsigned AW = 2;

    logic          clock;
    logic          reset;
    logic          load_valid;
    logic          load_ready;
    logic [W-1:0]  load_data;
    logic          flush;
    logic          rot_en;
    logic          rot_dir;
    logic [AW-1:0] rot_amt;
    logic [N*W-1:0] b_flat;
    logic [N*W-1:0] r_flat;
    logic          running;
    logic [AW-1:0] rot_count;
    logic          inv_ok;

    barrel_rotator_param #(.N(N), .W(W)) dut (
        .clock      (clock),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .flush      (flush),
        .rot_en     (rot_en),
        .rot_dir    (rot_dir),
        .rot_amt    (rot_amt),
        .b_flat     (b_flat),
        .r_flat     (r_flat),
        .running    (running),
        .rot_count  (rot_count),
        .inv_ok     (inv_ok)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct packed {
        logic [N*W-1:0] b;
        logic [N*W-1:0] r;
        logic           run;
        logic           lr;
        logic [AW-1:0]  cnt;
        logic           inv;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: plain arrays and modular arithmetic
    int bm [N];
    int rm [N];
    int ptr;
    int cnt;
    bit run;
    bit inv;

    function automatic bit inv_holds();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                if (rm[i] == bm[j] && rm[(i + 1) % N] != bm[(j + 1) % N]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic exp_t snapshot();
        exp_t e;
        e = '0;
        for (int k = 0; k < N; k++) begin
            e.b[k*W +: W] = W'(bm[k]);
            e.r[k*W +: W] = W'(rm[k]);
        end
        e.run = run;
        e.lr  = !run;
        e.cnt = AW'(cnt);
        e.inv = inv;
        return e;
    endfunction

    task automatic model_step(input bit rs, input bit lv, input int ld, input bit fl,
                              input bit re, input bit rd, input int ra);
        int nb [N];
        int sh;
        if (rs) begin
            for (int k = 0; k < N; k++) begin bm[k] = 0; rm[k] = 0; end
            ptr = 0; cnt = 0; run = 0; inv = 1;
            return;
        end
`ifdef INV_CHECK_EN
        inv = (run && !fl) ? inv_holds() : 1'b1;
`else
        inv = 1'b1;
`endif
        if (fl) begin
            for (int k = 0; k < N; k++) begin bm[k] = 0; rm[k] = 0; end
            ptr = 0; cnt = 0; run = 0;
        end else if (!run) begin
            if (lv) begin
                bm[ptr] = ld;
                rm[ptr] = ld;
                if (ptr == N - 1) begin ptr = 0; run = 1; end
                else ptr = ptr + 1;
            end
        end else if (re) begin
            sh = rd ? (N - ra) % N : ra;
            for (int i = 0; i < N; i++) nb[i] = bm[(i + sh) % N];
            for (int i = 0; i < N; i++) bm[i] = nb[i];
            cnt = (cnt + sh) % N;
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Monitor: compares every presented output cycle against the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("b_flat",     64'(b_flat),     64'(e.b));
                chk("r_flat",     64'(r_flat),     64'(e.r));
                chk("running",    64'(running),    64'(e.run));
                chk("load_ready", 64'(load_ready), 64'(e.lr));
                chk("rot_count",  64'(rot_count),  64'(e.cnt));
                chk("inv_ok",     64'(inv_ok),     64'(e.inv));
            end
        end
    end

    // One clock of stimulus; expected state pushed right after the edge
    task automatic cyc(input bit rs, input bit lv, input int ld, input bit fl,
                       input bit re, input bit rd, input int ra);
        reset      = rs;
        load_valid = lv;
        load_data  = W'(ld);
        flush      = fl;
        rot_en     = re;
        rot_dir    = rd;
        rot_amt    = AW'(ra);
        @(posedge clock);
        model_step(rs, lv, ld, fl, re, rd, ra);
        q.push_back(snapshot());
        @(negedge clock);
        #1;
    endtask

    task automatic fill4(input int a, input int b, input int c, input int d);
        cyc(0, 1, a, 0, 0, 0, 0);
        cyc(0, 1, b, 0, 0, 0, 0);
        cyc(0, 1, c, 0, 0, 0, 0);
        cyc(0, 1, d, 0, 0, 0, 0);
    endtask

    initial begin
        int guard;
        reset = 1'b1; load_valid = 1'b0; load_data = '0;
        flush = 1'b0; rot_en = 1'b0; rot_dir = 1'b0; rot_amt = '0;

        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 3, 0, 1, 0, 1);

        // Ordered fill, rot_en ignored during FILL
        cyc(0, 1, 0, 0, 1, 0, 1);
        cyc(0, 1, 1, 0, 0, 0, 0);
        cyc(0, 1, 2, 0, 0, 0, 0);
        cyc(0, 1, 3, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);

        // Four single-step up rotations back to the start
        for (int k = 0; k < 4; k++) cyc(0, 0, 0, 0, 1, 0, 1);
        // Down by N-1, then a zero-amount rotation, with load_valid held
        cyc(0, 1, 1, 0, 1, 1, 3);
        cyc(0, 1, 2, 0, 1, 0, 0);
        cyc(0, 1, 3, 0, 1, 1, 0);
        // Flush beats a same-cycle rotate
        cyc(0, 0, 0, 1, 1, 0, 2);
        cyc(0, 0, 0, 0, 0, 0, 0);

        // Invariant-violating contents
        fill4(1, 0, 1, 2);
        for (int k = 0; k < 3; k++) cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 1, 2);
        cyc(0, 1, 3, 1, 0, 0, 0);

        // Reset mid-fill, then a fresh fill
        cyc(0, 1, 2, 0, 0, 0, 0);
        cyc(0, 1, 3, 0, 0, 0, 0);
        cyc(1, 1, 1, 0, 0, 0, 0);
        fill4(3, 2, 1, 0);
        cyc(0, 0, 0, 0, 1, 1, 1);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 0, 1);

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            cyc(($urandom_range(0, 63) == 0),
                ($urandom_range(0, 3) != 0),
                int'($urandom_range(0, (1 << W) - 1)),
                ($urandom_range(0, 15) == 0),
                ($urandom_range(0, 3) != 0),
                $urandom_range(0, 1) == 1,
                int'($urandom_range(0, N - 1)));
        end
        cyc(0, 0, 0, 0, 0, 0, 0);

        guard = 0;
        while (q.size() > 0 && guard < 10) begin
            @(negedge clock);
            guard++;
        end
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
